// File: rtl/uart_rx_byte_buffer.sv
// UART Rx byte assembler plus first-word-fall-through output FIFO.
// Latency: rx_complete in cycle N gives o_valid/o_data in N+1; pop in N shows the next head in N+1.
// Backpressure: none toward the Rx FSM. A full FIFO with no pop drops the byte and sets o_overrun.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   catch_bit[_cnt]     per-bit decision and its index (8..15 ignored)
//   shift_rst           clears the assembly register while the FSM idles
//   rx_complete/error   frame-done / bad-stop-bit pulses
//   i_ready, o_data,
//   o_valid             valid/ready read port on the FIFO head
//   o_full, o_level     FIFO occupancy
//   i_clr_err,
//   o_overrun,
//   o_frame_err_cnt     host-side error status
module uart_rx_byte_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          catch_bit,
  input  logic [3:0]    catch_bit_cnt,
  input  logic          shift_rst,
  input  logic          rx_complete,
  input  logic          rx_error,
  input  logic          i_ready,
  input  logic          i_clr_err,
  output logic [7:0]    o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic [AW:0]   o_level,
  output logic          o_overrun,
  output logic [7:0]    o_frame_err_cnt
);

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    rx_byte;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;

  logic pop;
  logic push_req;
  logic wr_en;
  logic drop;

  // A framing error on the same cycle as rx_complete cancels the push.
  assign push_req = rx_complete & ~rx_error;
  assign pop      = o_valid & i_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_en    = push_req & (~o_full | pop);
  assign drop     = push_req & o_full & ~pop;

  assign o_valid = (level != '0);
  assign o_full  = (level == LVL_FULL);
  assign o_level = level;
  assign o_data  = mem[rd_ptr];

  // Assembly register: bit index 8..15 leaves the byte untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte <= '0;
    end else if (shift_rst) begin
      rx_byte <= '0;
    end else if (!catch_bit_cnt[3]) begin
      rx_byte[catch_bit_cnt[2:0]] <= catch_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  // Pointers wrap naturally at AW bits; occupancy is tracked by level only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Clear takes effect first; an event in the same cycle lands on top of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun       <= 1'b0;
      o_frame_err_cnt <= '0;
    end else begin
      if (i_clr_err) begin
        o_overrun <= drop;
      end else if (drop) begin
        o_overrun <= 1'b1;
      end

      if (i_clr_err) begin
        o_frame_err_cnt <= rx_error ? 8'd1 : 8'd0;
      end else if (rx_error && (o_frame_err_cnt != 8'hFF)) begin
        o_frame_err_cnt <= o_frame_err_cnt + 8'd1;
      end
    end
  end

endmodule
